// File: rtl/ult_arb.sv
// Two-requester arbiter sharing one unsigned less-than comparator.
// Round-robin grant in IDLE, compare in EXEC, hold the response in RESP until it is consumed.
module ult_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic             grant_id;
  logic             op_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             lt;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  // Gated by rst so req_ready stays low while reset is held, whatever req_valid does.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !rst && req_valid != 2'b00)
      req_ready = grant_id ? 2'b10 : 2'b01;
  end

  assign lt   = op_a < op_b;
  assign busy = state != IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready != 2'b00) begin
            op_a       <= grant_id ? req_a1 : req_a0;
            op_b       <= grant_id ? req_b1 : req_b0;
            op_id      <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= {WIDTH{lt}};
          rsp_flag   <= ~lt;
          rsp_id     <= op_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
